// File: rtl/clockport_read_port.sv
// Pi->Amiga read side of the clockport bridge: Pi pushes bytes into a small FIFO,
// and each synchronised clockport read cycle returns either the head byte or a status byte.
module clockport_read_port #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_pi_d,
  input  logic       i_pi_wr,
  output logic       o_pi_full,
  output logic [3:0] o_pi_level,
  input  logic       i_cp_cs_n,
  input  logic       i_cp_rd_n,
  input  logic       i_cp_a,
  output logic [7:0] o_cp_q,
  output logic       o_cp_oe_n,
  output logic       o_cp_int_n
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LVL_FULL = 4'(DEPTH);

  typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_rd_sync;
  logic [7:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [3:0]             r_level, w_level_next;
  logic                   r_full, r_int_n, r_udf, r_ovf, r_a_q, r_was_ne, r_oe_n;
  logic [7:0]             r_cp_q, w_status;
  logic                   w_rd_act, w_empty, w_is_full;
  logic                   w_load, w_pop, w_clr, w_push, w_ovf_evt;

  assign w_rd_act  = ~r_cs_sync[SYNC_STAGES-1] & ~r_rd_sync[SYNC_STAGES-1];
  assign w_empty   = (r_level == 4'd0);
  assign w_is_full = (r_level == LVL_FULL);
  assign w_status  = {r_udf, r_ovf, w_is_full, w_empty, r_level};

  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted then.
  assign w_push       = i_pi_wr & (~w_is_full | w_pop);
  assign w_ovf_evt    = i_pi_wr & w_is_full & ~w_pop;
  assign w_level_next = r_level + {3'b000, w_push} - {3'b000, w_pop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_sync <= '1;
      r_rd_sync <= '1;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], i_cp_cs_n};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], i_cp_rd_n};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_act) begin
          w_state_next = ST_DRIVE;
          w_load       = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!w_rd_act) begin
          w_state_next = ST_IDLE;
          w_pop        = ~r_a_q & r_was_ne;
          w_clr        = r_a_q;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_oe_n   <= 1'b1;
      r_cp_q   <= 8'h00;
      r_a_q    <= 1'b0;
      r_was_ne <= 1'b0;
      r_udf    <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
      r_full   <= 1'b0;
      r_int_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_oe_n  <= (w_state_next != ST_DRIVE);
      if (w_load) begin
        r_a_q    <= i_cp_a;
        r_was_ne <= ~w_empty;
        if (i_cp_a)
          r_cp_q <= w_status;
        else
          r_cp_q <= w_empty ? 8'h00 : r_mem[r_rd_ptr];
      end
      // A fresh event on the clearing edge stays visible to the next status read.
      if (w_load && !i_cp_a && w_empty)
        r_udf <= 1'b1;
      else if (w_clr)
        r_udf <= 1'b0;
      if (w_ovf_evt)
        r_ovf <= 1'b1;
      else if (w_clr)
        r_ovf <= 1'b0;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_int_n <= (w_level_next == 4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_pi_d;
  end

  assign o_pi_full  = r_full;
  assign o_pi_level = r_level;
  assign o_cp_q     = r_cp_q;
  assign o_cp_oe_n  = r_oe_n;
  assign o_cp_int_n = r_int_n;
endmodule

// File: tb/tb_clockport_read_port.sv
// Bench for clockport_read_port: fixed vector table, hand-written multi-cycle corners,
// and a randomized phase checked against a byte-queue reference model.
module tb_clockport_read_port;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pi_d;
  logic       pi_wr;
  logic       pi_full;
  logic [3:0] pi_level;
  logic       cs_n, rd_n, cp_a;
  logic [7:0] cp_q;
  logic       oe_n, int_n;

  int n_vec = 0;
  int n_mis = 0;

  clockport_read_port #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pi_d     (pi_d),
    .i_pi_wr    (pi_wr),
    .o_pi_full  (pi_full),
    .o_pi_level (pi_level),
    .i_cp_cs_n  (cs_n),
    .i_cp_rd_n  (rd_n),
    .i_cp_a     (cp_a),
    .o_cp_q     (cp_q),
    .o_cp_oe_n  (oe_n),
    .o_cp_int_n (int_n)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue plus the two sticky flags.
  logic [7:0] mq[$];
  logic       m_udf, m_ovf;

  function automatic void m_reset();
    mq.delete();
    m_udf = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [7:0] m_read(input logic a);
    logic [7:0] r;
    if (a) begin
      r = {m_udf, m_ovf, mq.size() == DEPTH, mq.size() == 0, 4'(mq.size())};
      m_udf = 1'b0;
      m_ovf = 1'b0;
    end else if (mq.size() == 0) begin
      r = 8'h00;
      m_udf = 1'b1;
    end else begin
      r = mq.pop_front();
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    pi_d  = b;
    pi_wr = 1'b1;
    @(posedge clk); #1;
    pi_wr = 1'b0;
    m_push(b);
  endtask

  task automatic wait_oe(input logic lvl, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (oe_n !== lvl && lat < 20);
  endtask

  task automatic bus_read(input logic a, input int hold, output logic [7:0] q);
    int lat;
    cp_a = a; cs_n = 1'b0; rd_n = 1'b0;
    wait_oe(1'b0, lat);
    chk("oe_fall_latency", lat, LAT);
    q = cp_q;
    repeat (hold) begin @(posedge clk); #1; end
    cs_n = 1'b1; rd_n = 1'b1;
    wait_oe(1'b1, lat);
    chk("oe_rise_latency", lat, LAT);
  endtask

  typedef struct {
    bit         is_read;
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_q;
    int         exp_level;
    logic       exp_full;
    logic       exp_int_n;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, logic a, logic [7:0] d, logic [7:0] q, int lv, logic f, logic in);
    vec_t v;
    v.is_read = r; v.a = a; v.d = d; v.exp_q = q;
    v.exp_level = lv; v.exp_full = f; v.exp_int_n = in;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] q, q0, exp;
    int         lat;
    bit         ok;

    rst_n = 1'b0; pi_d = 8'h00; pi_wr = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; cp_a = 1'b0;
    m_reset();

    // Basic reads, underflow status, overflow status and in-order drain.
    add(0, 0, 8'hA5, 0,     1, 0, 0);
    add(0, 0, 8'h3C, 0,     2, 0, 0);
    add(1, 0, 0,     8'hA5, 1, 0, 0);
    add(1, 0, 0,     8'h3C, 0, 0, 1);
    add(1, 0, 0,     8'h00, 0, 0, 1);
    add(1, 1, 0,     8'h90, 0, 0, 1);
    add(1, 1, 0,     8'h10, 0, 0, 1);
    add(0, 0, 8'h11, 0,     1, 0, 0);
    add(0, 0, 8'h22, 0,     2, 0, 0);
    add(0, 0, 8'h33, 0,     3, 0, 0);
    add(0, 0, 8'h44, 0,     4, 1, 0);
    add(0, 0, 8'h55, 0,     4, 1, 0);
    add(1, 1, 0,     8'h64, 4, 1, 0);
    add(1, 0, 0,     8'h11, 3, 0, 0);
    add(1, 0, 0,     8'h22, 2, 0, 0);
    add(1, 0, 0,     8'h33, 1, 0, 0);
    add(1, 0, 0,     8'h44, 0, 0, 1);
    add(1, 1, 0,     8'h10, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe_n", oe_n, 1);
    chk("reset_q", cp_q, 0);
    chk("reset_int_n", int_n, 1);
    chk("reset_full", pi_full, 0);
    chk("reset_level", pi_level, 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    foreach (tbl[i]) begin
      if (tbl[i].is_read) begin
        exp = m_read(tbl[i].a);
        bus_read(tbl[i].a, 2, q);
        chk("table_q", q, tbl[i].exp_q);
        $display("vec %0d: read A=%0d q=%02h", i, tbl[i].a, q);
      end else begin
        push(tbl[i].d);
        $display("vec %0d: push %02h level=%0d", i, tbl[i].d, pi_level);
      end
      chk("table_level", pi_level, tbl[i].exp_level);
      chk("table_full", pi_full, tbl[i].exp_full);
      chk("table_int_n", int_n, tbl[i].exp_int_n);
    end

    // Push on the exact pop edge while full, repeated so the pointers wrap.
    for (int round = 0; round < 3; round++) begin
      while (mq.size() < DEPTH) push(8'($urandom));
      chk("fill_full", pi_full, 1);
      exp = m_read(1'b0);
      m_push(8'(8'hE0 + round));
      cp_a = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
      wait_oe(1'b0, lat);
      chk("pp_fall_latency", lat, LAT);
      chk("pp_q", cp_q, exp);
      cs_n = 1'b1; rd_n = 1'b1;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      pi_d = 8'(8'hE0 + round); pi_wr = 1'b1;
      @(posedge clk); #1;
      pi_wr = 1'b0;
      chk("pp_exit_edge", oe_n, 1);
      chk("pp_level", pi_level, DEPTH);
      chk("pp_full", pi_full, 1);
      $display("round %0d: pop+push on same edge, level=%0d", round, pi_level);
      while (mq.size() > 0) begin
        exp = m_read(1'b0);
        bus_read(1'b0, 0, q);
        chk("pp_drain_q", q, exp);
      end
      chk("pp_empty_int_n", int_n, 1);
    end

    // Long strobe with a push in the middle: frozen output, exactly one pop.
    push(8'h5A);
    push(8'h6B);
    exp = m_read(1'b0);
    cp_a = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
    wait_oe(1'b0, lat);
    chk("long_fall_latency", lat, LAT);
    q0 = cp_q;
    chk("long_q", q0, exp);
    ok = 1'b1;
    pi_d = 8'hC7;
    for (int i = 0; i < 50; i++) begin
      pi_wr = (i == 10);
      @(posedge clk); #1;
      if (cp_q !== q0 || oe_n !== 1'b0) ok = 1'b0;
    end
    pi_wr = 1'b0;
    m_push(8'hC7);
    chk("long_q_stable", ok, 1);
    cs_n = 1'b1; rd_n = 1'b1;
    wait_oe(1'b1, lat);
    chk("long_rise_latency", lat, LAT);
    chk("long_one_pop", pi_level, 2);
    $display("long read: q=%02h level=%0d", q0, pi_level);
    while (mq.size() > 0) begin
      exp = m_read(1'b0);
      bus_read(1'b0, 1, q);
      chk("long_drain_q", q, exp);
    end

    // Only one strobe low is not a read.
    push(8'h99);
    cs_n = 1'b1; rd_n = 1'b0;
    ok = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (oe_n !== 1'b1) ok = 1'b0; end
    cs_n = 1'b0; rd_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (oe_n !== 1'b1) ok = 1'b0; end
    cs_n = 1'b1;
    chk("half_strobe_no_read", ok, 1);
    chk("half_strobe_level", pi_level, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 99) < 50) begin
        q = 8'($urandom);
        push(q);
        $display("rand %0d: push %02h level=%0d", i, q, pi_level);
      end else begin
        cp_a = 1'($urandom_range(0, 1));
        exp = m_read(cp_a);
        bus_read(cp_a, $urandom_range(0, 3), q);
        chk("rand_q", q, exp);
        $display("rand %0d: read A=%0d q=%02h", i, cp_a, q);
      end
      chk("rand_level", pi_level, mq.size());
      chk("rand_int_n", int_n, mq.size() == 0);
    end

    // Reset in the middle of a driven read.
    push(8'h77);
    cp_a = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
    wait_oe(1'b0, lat);
    chk("rst_pre_oe", oe_n, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_oe", oe_n, 1);
    chk("rst_async_level", pi_level, 0);
    cs_n = 1'b1; rd_n = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (oe_n !== 1'b1) ok = 1'b0; end
    chk("rst_no_spurious", ok, 1);
    chk("rst_level", pi_level, 0);
    chk("rst_q", cp_q, 0);
    chk("rst_int_n", int_n, 1);
    exp = m_read(1'b1);
    bus_read(1'b1, 1, q);
    chk("rst_status", q, exp);
    $display("after reset: status=%02h", q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
